// File: rtl/dbus_arbiter.sv
// Data-bus arbiter: serialises the two Memory-stage slot requests onto one core
// data bus. Slot 1 always wins, and the granted request is held until addr_ok.
package dbus_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

module dbus_arbiter
  import dbus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq_1,
  input  dbus_req_t  dreq_2,
  output dbus_resp_t dresp_1,
  output dbus_resp_t dresp_2,
  output dbus_req_t  dreq,
  input  dbus_resp_t dresp,
  input  logic       advance
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  typedef enum logic {OWN_1, OWN_2} owner_e;

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  dbus_req_t  held_q, held_d;
  logic       served_1_q, served_1_d;
  logic       served_2_q, served_2_d;

  dbus_resp_t fwd;
  logic       complete;

  // NOTE: every signal written here gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    held_d   = held_q;
    dreq     = '0;
    fwd      = '0;
    complete = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (dreq_1.valid && !served_1_q) begin
          held_d  = dreq_1;
          owner_d = OWN_1;
          state_d = S_REQ;
        end else if (dreq_2.valid && !served_2_q) begin
          held_d  = dreq_2;
          owner_d = OWN_2;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        dreq         = held_q;
        dreq.valid   = 1'b1;
        fwd.addr_ok  = dresp.addr_ok;
        // A data_ok arriving before addr_ok is a bus error and is dropped.
        fwd.data_ok  = dresp.addr_ok & dresp.data_ok;
        fwd.data     = dresp.data;
        if (dresp.addr_ok) begin
          complete = dresp.data_ok;
          state_d  = dresp.data_ok ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        fwd.data_ok = dresp.data_ok;
        fwd.data    = dresp.data;
        if (dresp.data_ok) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dresp_1 = (owner_q == OWN_1) ? fwd : '0;
    dresp_2 = (owner_q == OWN_2) ? fwd : '0;

    // A dropped valid yields to a completing access; advance beats both.
    served_1_d = served_1_q;
    if (!dreq_1.valid)                   served_1_d = 1'b0;
    if (complete && (owner_q == OWN_1))  served_1_d = 1'b1;
    if (advance)                         served_1_d = 1'b0;

    served_2_d = served_2_q;
    if (!dreq_2.valid)                   served_2_d = 1'b0;
    if (complete && (owner_q == OWN_2))  served_2_d = 1'b1;
    if (advance)                         served_2_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_1;
      held_q     <= '0;
      served_1_q <= 1'b0;
      served_2_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      held_q     <= held_d;
      served_1_q <= served_1_d;
      served_2_q <= served_2_d;
    end
  end

  a_no_early_data_ok: assert property (
    @(posedge clk) disable iff (reset)
      (state_q == S_REQ && dresp.data_ok) |-> dresp.addr_ok
  ) else $error("dbus_arbiter: data_ok without addr_ok during REQ");

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a transaction-level model.
module tb_dbus_arbiter;
  import dbus_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       advance;
  dbus_req_t  dreq_1, dreq_2, dreq;
  dbus_resp_t dresp_1, dresp_2, dresp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dbus_arbiter dut (
    .clk     (clk),
    .reset   (reset),
    .dreq_1  (dreq_1),
    .dreq_2  (dreq_2),
    .dresp_1 (dresp_1),
    .dresp_2 (dresp_2),
    .dreq    (dreq),
    .dresp   (dresp),
    .advance (advance)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic dbus_req_t mk_req(input logic v, input logic [31:0] a, input logic [31:0] d);
    dbus_req_t r;
    r        = '0;
    r.valid  = v;
    r.addr   = a;
    r.size   = 2'd2;
    r.strobe = 4'hF;
    r.data   = d;
    return r;
  endfunction

  function automatic dbus_resp_t rsp(input logic aok, input logic dok, input logic [31:0] d);
    dbus_resp_t r;
    r.addr_ok = aok;
    r.data_ok = dok;
    r.data    = d;
    return r;
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are checked 2 later.
  task automatic settle(); #2; endtask
  task automatic next();   @(posedge clk); #1; endtask

  task automatic do_reset();
    reset   = 1'b1;
    advance = 1'b0;
    dreq_1  = '0;
    dreq_2  = '0;
    dresp   = '0;
    next();
    next();
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " dreq"},    128'(dreq),    128'(0));
    check({tag, " dresp_1"}, 128'(dresp_1), 128'(0));
    check({tag, " dresp_2"}, 128'(dresp_2), 128'(0));
  endtask

  typedef struct {
    logic        adv, v1, v2;
    dbus_resp_t  bus;
    logic        ev;
    logic [31:0] eaddr;
    dbus_resp_t  e1, e2;
  } vec_t;

  vec_t vecs[12];

  // Transaction-level reference: one optional in-flight access plus served bits.
  bit          m_busy, m_addr_done;
  int          m_owner;
  dbus_req_t   m_req;
  bit          m_served[2];

  initial begin
    dbus_resp_t z;
    z = '0;

    // ---------------- reset state ----------------
    do_reset();
    settle();
    check_idle_outputs("reset");
    check("reset served_1", 128'(dut.served_1_q), 128'(0));
    check("reset served_2", 128'(dut.served_2_q), 128'(0));
    next();

    // ---------------- table: slot-1 store, advance gating, slot-2 follow-up ----------------
    vecs[0]  = '{1'b0, 1'b1, 1'b0, z,                          1'b0, 32'h0,         z,                          z};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, rsp(1'b1, 1'b1, 32'h0),     1'b1, 32'h8000_0010, rsp(1'b1, 1'b1, 32'h0),     z};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, z,                          1'b0, 32'h0,         z,                          z};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, z,                          1'b0, 32'h0,         z,                          z};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, z,                          1'b0, 32'h0,         z,                          z};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, z,                          1'b0, 32'h0,         z,                          z};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, rsp(1'b1, 1'b0, 32'h0),     1'b1, 32'h8000_0010, rsp(1'b1, 1'b0, 32'h0),     z};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, rsp(1'b0, 1'b1, 32'h11),    1'b0, 32'h0,         rsp(1'b0, 1'b1, 32'h11),    z};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, z,                          1'b0, 32'h0,         z,                          z};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, rsp(1'b1, 1'b1, 32'h22),    1'b1, 32'h104,       z,                          rsp(1'b1, 1'b1, 32'h22)};
    vecs[10] = '{1'b1, 1'b1, 1'b1, z,                          1'b0, 32'h0,         z,                          z};
    vecs[11] = '{1'b0, 1'b0, 1'b0, z,                          1'b0, 32'h0,         z,                          z};

    for (int i = 0; i < 12; i++) begin
      advance = vecs[i].adv;
      dreq_1  = mk_req(vecs[i].v1, 32'h8000_0010, 32'hDEAD_BEEF);
      dreq_2  = mk_req(vecs[i].v2, 32'h104, 32'h0);
      dresp   = vecs[i].bus;
      settle();
      check($sformatf("vec%0d dreq", i), 128'({dreq.valid, dreq.addr}), 128'({vecs[i].ev, vecs[i].eaddr}));
      check($sformatf("vec%0d dresp_1", i), 128'(dresp_1), 128'(vecs[i].e1));
      check($sformatf("vec%0d dresp_2", i), 128'(dresp_2), 128'(vecs[i].e2));
      next();
    end

    // ---------------- both slots load, data_ok 3 cycles after addr_ok ----------------
    do_reset();
    dreq_1 = mk_req(1'b1, 32'h100, 32'h0);
    dreq_2 = mk_req(1'b1, 32'h104, 32'h0);
    for (int s = 0; s < 2; s++) begin
      dresp = '0;
      settle();
      check($sformatf("load%0d idle", s), 128'(dreq.valid), 128'(0));
      next();
      dresp = rsp(1'b1, 1'b0, 32'h0);
      settle();
      check($sformatf("load%0d addr", s), 128'({dreq.valid, dreq.addr}), 128'({1'b1, (s == 0) ? 32'h100 : 32'h104}));
      next();
      for (int w = 0; w < 2; w++) begin
        dresp = '0;
        settle();
        check($sformatf("load%0d no early data_ok", s), 128'({dresp_1.data_ok, dresp_2.data_ok}), 128'(0));
        next();
      end
      dresp = rsp(1'b0, 1'b1, (s == 0) ? 32'h11 : 32'h22);
      settle();
      check($sformatf("load%0d dresp_1", s), 128'(dresp_1), (s == 0) ? 128'(rsp(1'b0, 1'b1, 32'h11)) : 128'(0));
      check($sformatf("load%0d dresp_2", s), 128'(dresp_2), (s == 1) ? 128'(rsp(1'b0, 1'b1, 32'h22)) : 128'(0));
      next();
    end
    dresp = '0;
    settle();
    check("load both served", 128'(dreq.valid), 128'(0));
    next();
    next();
    settle();
    check("load no regrant", 128'(dreq.valid), 128'(0));

    // ---------------- addr_ok stall while slot 1 changes its address ----------------
    do_reset();
    dreq_1 = mk_req(1'b1, 32'h100, 32'h0);
    next();
    for (int c = 0; c < 6; c++) begin
      if (c > 0) dreq_1.addr = 32'h200;
      dresp = (c == 5) ? rsp(1'b1, 1'b1, 32'h0) : dbus_resp_t'('0);
      settle();
      check($sformatf("stall cyc%0d", c), 128'({dreq.valid, dreq.addr}), 128'({1'b1, 32'h100}));
      next();
    end

    // ---------------- slot 2 drops valid during WAIT ----------------
    do_reset();
    dreq_2 = mk_req(1'b1, 32'h104, 32'h0);
    next();
    dresp = rsp(1'b1, 1'b0, 32'h0);
    next();
    dreq_2.valid = 1'b0;
    dresp = rsp(1'b0, 1'b1, 32'h33);
    settle();
    check("abort dresp_2", 128'(dresp_2), 128'(rsp(1'b0, 1'b1, 32'h33)));
    next();
    dresp = '0;
    settle();
    check_idle_outputs("abort idle");
    next();
    check("abort served_2", 128'(dut.served_2_q), 128'(0));

    // ---------------- reset while in WAIT ----------------
    do_reset();
    dreq_1 = mk_req(1'b1, 32'h100, 32'h0);
    next();
    dresp = rsp(1'b1, 1'b0, 32'h0);
    next();
    reset = 1'b1;
    dresp = '0;
    next();
    reset  = 1'b0;
    dreq_1 = '0;
    dresp  = rsp(1'b0, 1'b1, 32'h55);
    settle();
    check_idle_outputs("rst-wait");
    check("rst-wait served", 128'({dut.served_1_q, dut.served_2_q}), 128'(0));
    next();

    // ---------------- random traffic vs reference model ----------------
    do_reset();
    m_busy = 0; m_addr_done = 0; m_owner = 0; m_req = '0;
    m_served[0] = 0; m_served[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      dbus_req_t  rq[2];
      dbus_req_t  e_dreq;
      dbus_resp_t e_fwd;
      bit         fired, new_served[2];

      reset   = ($urandom_range(0, 199) == 0);
      advance = ($urandom_range(0, 5) == 0);
      dreq_1  = mk_req($urandom_range(0, 3) != 0, $urandom, $urandom);
      dreq_2  = mk_req($urandom_range(0, 3) != 0, $urandom, $urandom);
      dreq_1.strobe = 4'($urandom);
      dreq_2.size   = 2'($urandom);
      dresp.addr_ok = 1'($urandom);
      dresp.data_ok = 1'($urandom);
      dresp.data    = $urandom;
      if (m_busy && !m_addr_done && !dresp.addr_ok) dresp.data_ok = 1'b0;
      rq[0] = dreq_1;
      rq[1] = dreq_2;
      settle();

      e_dreq = '0;
      e_fwd  = '0;
      fired  = 0;
      if (m_busy && !m_addr_done) begin
        e_dreq       = m_req;
        e_dreq.valid = 1'b1;
      end
      if (m_busy) begin
        e_fwd.data = dresp.data;
        if (!m_addr_done) begin
          e_fwd.addr_ok = dresp.addr_ok;
          fired = dresp.addr_ok && dresp.data_ok;
        end else begin
          fired = dresp.data_ok;
        end
        e_fwd.data_ok = fired;
      end
      check("rand dreq",    128'(dreq),    128'(e_dreq));
      check("rand dresp_1", 128'(dresp_1), (m_busy && m_owner == 0) ? 128'(e_fwd) : 128'(0));
      check("rand dresp_2", 128'(dresp_2), (m_busy && m_owner == 1) ? 128'(e_fwd) : 128'(0));

      @(posedge clk);
      if (reset) begin
        m_busy = 0; m_addr_done = 0; m_owner = 0; m_req = '0;
        m_served[0] = 0; m_served[1] = 0;
      end else begin
        for (int x = 0; x < 2; x++) begin
          new_served[x] = m_served[x];
          if (!rq[x].valid)            new_served[x] = 0;
          if (fired && m_owner == x)   new_served[x] = 1;
          if (advance)                 new_served[x] = 0;
        end
        if (!m_busy) begin
          for (int x = 0; x < 2; x++) begin
            if (!m_busy && rq[x].valid && !m_served[x]) begin
              m_busy = 1; m_addr_done = 0; m_owner = x; m_req = rq[x];
            end
          end
        end else if (fired) begin
          m_busy = 0;
        end else if (!m_addr_done && dresp.addr_ok) begin
          m_addr_done = 1;
        end
        m_served[0] = new_served[0];
        m_served[1] = new_served[1];
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
